// File: rtl/position_decoder.sv
// Position decoder: turns a stream of offset-coded 8-bit table addresses back
// into a 32-bit absolute angle. The angle is built from a loaded reference,
// a signed turn counter and the current 8-bit delta. The turn counter is
// updated whenever consecutive deltas jump by more than half a turn.
module position_decoder #(
  parameter int         TURN_W = 16,
  parameter logic [7:0] OFFSET = 8'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ref_load,
  // `ref` is a reserved word in SystemVerilog, so the reference port is ref_angle.
  input  logic [15:0] ref_angle,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  address,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] theta,
  output logic        turn_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic signed [TURN_W-1:0] TURN_ONE = TURN_W'(1);
  localparam logic signed [TURN_W-1:0] TURN_MAX = {1'b0, {(TURN_W-1){1'b1}}};
  localparam logic signed [TURN_W-1:0] TURN_MIN = {1'b1, {(TURN_W-1){1'b0}}};
  localparam logic signed [8:0]        DIFF_HI  = 9'sd127;
  localparam logic signed [8:0]        DIFF_LO  = -9'sd128;

  state_t                    state;
  logic [15:0]               ref_q;
  logic signed [TURN_W-1:0]  turns;
  logic signed [7:0]         prev_delta;

  logic signed [7:0]         delta;
  logic signed [8:0]         diff;
  logic signed [TURN_W-1:0]  turns_new;
  logic                      step_ovf;
  logic                      accept;
  logic [31:0]               theta_next;

  // A new sample may enter only when a reference is held, no reload is in
  // progress, and the output register is empty or being drained this cycle.
  assign in_ready = (state != IDLE) & ~ref_load & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Decode the sample: delta, unwrap decision and the resulting absolute angle.
  always_comb begin
    // NOTE: every variable gets a default before the branches so no path
    // leaves it unassigned, which would otherwise infer a latch.
    delta     = signed'(address - OFFSET);
    diff      = {delta[7], delta} - {prev_delta[7], prev_delta};
    turns_new = turns;
    step_ovf  = 1'b0;
    if (state == TRACK) begin
      if (diff > DIFF_HI) begin
        // Large positive jump: the encoder wrapped backwards through -128.
        turns_new = turns - TURN_ONE;
        step_ovf  = (turns == TURN_MIN);
      end else if (diff < DIFF_LO) begin
        // Large negative jump: the encoder wrapped forwards through +127.
        turns_new = turns + TURN_ONE;
        step_ovf  = (turns == TURN_MAX);
      end
    end
    theta_next = {16'b0, ref_q}
               + {{(24-TURN_W){turns_new[TURN_W-1]}}, turns_new, 8'b0}
               + {{24{delta[7]}}, delta};
  end

  // Control FSM, unwrap state and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ref_q      <= '0;
      turns      <= '0;
      prev_delta <= '0;
      out_valid  <= 1'b0;
      theta      <= '0;
      turn_ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (accept) begin
        theta      <= theta_next;
        out_valid  <= 1'b1;
        turns      <= turns_new;
        prev_delta <= delta;
        if (step_ovf) begin
          turn_ovf <= 1'b1;
        end
        if (state == FIRST) begin
          state <= TRACK;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A reload restarts unwrapping but leaves any pending output in place.
      if (ref_load) begin
        state    <= FIRST;
        ref_q    <= ref_angle;
        turns    <= '0;
        turn_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_position_decoder.sv
// Bench for position_decoder: a default instance and a TURN_W=2 instance share
// all inputs; a behavioural model predicts handshakes, flags and angles, and
// expected angles travel through a scoreboard queue to the output side.
module tb_position_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ref_load = 1'b0;
  logic [15:0] ref_angle = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  address = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, in_ready_s;
  logic        out_valid, out_valid_s;
  logic [31:0] theta, theta_s;
  logic        turn_ovf, turn_ovf_s;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] t16;
    logic [31:0] t2;
  } exp_t;
  exp_t sb[$];

  // Model state
  int m_state;          // 0 idle, 1 first, 2 track
  int m_ref, m_t16, m_t2, m_prev;
  bit m_ovf16, m_ovf2, m_out_valid;

  always #5 clk = ~clk;

  position_decoder dut (
    .clk(clk), .rst(rst), .ref_load(ref_load), .ref_angle(ref_angle),
    .in_valid(in_valid), .in_ready(in_ready), .address(address),
    .out_valid(out_valid), .out_ready(out_ready), .theta(theta),
    .turn_ovf(turn_ovf)
  );

  position_decoder #(.TURN_W(2)) dut_s (
    .clk(clk), .rst(rst), .ref_load(ref_load), .ref_angle(ref_angle),
    .in_valid(in_valid), .in_ready(in_ready_s), .address(address),
    .out_valid(out_valid_s), .out_ready(out_ready), .theta(theta_s),
    .turn_ovf(turn_ovf_s)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d) at %0t",
                  tag, act, act, exp, exp, $time);
  endtask

  function automatic int wrap_turns(input int n, input int w);
    int lim = 1 << (w - 1);
    if (n >= lim) return n - 2 * lim;
    if (n < -lim) return n + 2 * lim;
    return n;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ref = 0; m_t16 = 0; m_t2 = 0; m_prev = 0;
    m_ovf16 = 0; m_ovf2 = 0; m_out_valid = 0;
    sb.delete();
  endtask

  // Per-cycle compare and model update, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      bit   exp_ready;
      int   d, step, n16, n2;
      exp_t e;
      exp_ready = (m_state != 0) && !ref_load && (!m_out_valid || out_ready);
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      check("in_ready_s", {31'b0, in_ready_s}, {31'b0, exp_ready});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_out_valid});
      check("turn_ovf", {31'b0, turn_ovf}, {31'b0, m_ovf16});
      check("turn_ovf_s", {31'b0, turn_ovf_s}, {31'b0, m_ovf2});
      if (m_out_valid && sb.size() > 0) begin
        check("theta", theta, sb[0].t16);
        check("theta_s", theta_s, sb[0].t2);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", {31'b0, out_valid}, 32'd0);
        else void'(sb.pop_front());
      end

      // Advance the model to the state after the coming rising edge.
      if (m_out_valid && out_ready) m_out_valid = 0;
      if (exp_ready && in_valid) begin
        d = int'(address) - 128;
        step = 0;
        if (m_state == 2) begin
          if (d - m_prev > 127) step = -1;
          else if (d - m_prev < -128) step = 1;
        end
        n16 = wrap_turns(m_t16 + step, 16);
        n2  = wrap_turns(m_t2 + step, 2);
        if (n16 != m_t16 + step) m_ovf16 = 1;
        if (n2 != m_t2 + step) m_ovf2 = 1;
        m_t16 = n16; m_t2 = n2; m_prev = d; m_state = 2;
        e.t16 = 32'(m_ref + m_t16 * 256 + d);
        e.t2  = 32'(m_ref + m_t2 * 256 + d);
        sb.push_back(e);
        m_out_valid = 1;
      end
      if (ref_load) begin
        m_state = 1; m_ref = int'(ref_angle); m_t16 = 0; m_t2 = 0;
        m_ovf16 = 0; m_ovf2 = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic load(input int v);
    ref_load = 1'b1;
    ref_angle = 16'(v);
    tick();
    ref_load = 1'b0;
  endtask

  task automatic send(input logic [7:0] a);
    bit got = 0;
    in_valid = 1'b1;
    address = a;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) check("send_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] seq6 [7] = '{8'd128, 8'd255, 8'd0, 8'd64, 8'd128, 8'd255, 8'd0};
    model_reset();
    #1;
    do_reset();

    // Reset values
    check("rst_theta", theta, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_turn_ovf", {31'b0, turn_ovf}, 32'd0);

    // Basic single sample, then forward wrap
    out_ready = 1'b1;
    load(1000);
    send(8'd128);
    tick();
    load(1000);
    send(8'd128); send(8'd200); send(8'd255); send(8'd0);
    tick(); tick();

    // Backward wrap
    load(500);
    send(8'd128); send(8'd0); send(8'd255);
    tick(); tick();

    // Backpressure: hold output, then release while a sample waits
    out_ready = 1'b0;
    send(8'd10);
    fork
      send(8'd20);
      begin repeat (4) tick(); out_ready = 1'b1; end
    join
    send(8'd30);
    tick(); tick();

    // Reload with a sample presented at the same time: sample dropped
    ref_load = 1'b1; ref_angle = 16'd2000; in_valid = 1'b1; address = 8'd50;
    tick();
    ref_load = 1'b0; in_valid = 1'b0;
    tick();
    send(8'd50); send(8'd60);
    tick(); tick();

    // Reload while an output is pending: it is still delivered
    out_ready = 1'b0;
    send(8'd90);
    load(300);
    tick(); tick();
    out_ready = 1'b1;
    send(8'd128);
    tick(); tick();

    // Two forward wraps overflow the 2-bit turn counter; reload clears it
    load(0);
    foreach (seq6[i]) send(seq6[i]);
    tick(); tick();
    load(7);
    send(8'd128);
    tick(); tick();

    // Random stream with random backpressure
    load(16'hFFF0);
    fork
      for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)));
      begin
        for (int i = 0; i < 60; i++) begin out_ready = 1'($urandom_range(0, 1)); tick(); end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
    check("sb_drain", sb.size(), 32'd0);

    // Reset mid-operation discards pending output
    load(1234);
    out_ready = 1'b0;
    send(8'd140);
    do_reset();
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_theta", theta, 32'd0);
    out_ready = 1'b1;
    load(42);
    send(8'd129);
    tick(); tick();
    check("final_drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
